// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: issues word-aligned reads to instruction memory and
// buffers returned words with their PCs for decode. A redirect flushes the buffer.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_pc
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_q, fetch_d;
  logic [31:0]     pend_q, pend_d;
  logic [63:0]     buf_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   count_q;

  logic        req_int;
  logic        acked;
  logic        pending;
  logic        push;
  logic        pop;
  logic [31:0] redir_aligned;
  logic        unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redir_aligned       = {redirect_pc[31:2], 2'b00};

  assign req_int = (state_q == S_IDLE) ? (count_q < DEPTH_C) : 1'b1;
  assign acked   = req_int & imem_ack;
  assign pending = req_int & ~imem_ack;

  // fetch_q holds the outstanding address in WAIT/DISCARD, so it doubles as imem_addr.
  assign imem_req  = req_int & clr_n;
  assign imem_addr = fetch_q;
  assign fetch_pc  = (state_q == S_DISCARD) ? pend_q : fetch_q;

  assign inst_valid = (count_q != '0);
  assign inst_data  = buf_q[rd_q][63:32];
  assign inst_pc    = buf_q[rd_q][31:0];

  assign push = acked & (state_q != S_DISCARD) & ~redirect_valid;
  assign pop  = inst_valid & inst_ready & ~redirect_valid;

  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    pend_d  = pend_q;
    if (redirect_valid) begin
      if (pending) begin
        state_d = S_DISCARD;
        pend_d  = redir_aligned;
      end else begin
        state_d = S_IDLE;
        fetch_d = redir_aligned;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (acked)        fetch_d = fetch_q + 32'd4;
          else if (pending) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (acked) begin
            fetch_d = fetch_q + 32'd4;
            state_d = S_IDLE;
          end
        end
        S_DISCARD: begin
          if (acked) begin
            fetch_d = pend_q;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      fetch_q <= RESET_PC;
      pend_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) buf_q[i] <= '0;
    end else if (redirect_valid) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        buf_q[wr_q] <= {imem_rdata, imem_addr};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected {pc,data} pairs are queued as stimulus
// is applied and popped as decode accepts each head entry.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] fetch_pc;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [63:0] mk(input logic [31:0] pc);
    return {pc, mem_word(pc)};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .clr_n(clr_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .fetch_pc(fetch_pc)
  );

  task automatic apply_reset(input logic ack, input logic rdy);
    @(negedge clk);
    clr_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = ack; inst_ready = rdy;
    exp_q.delete();
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    clr_n = 1'b0; imem_ack = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    n_cmp++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL rst_fetch_pc: got %h want 0", fetch_pc); end
    n_cmp++; if (inst_pc !== 32'h0 || inst_data !== 32'h0) begin n_fail++; $display("FAIL rst_head: got %h/%h want 0/0", inst_pc, inst_data); end
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got %b@%h want 1@0", imem_req, imem_addr); end
  endtask

  task automatic test_stream;
    bit started = 0;
    apply_reset(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(32'(i * 4)));
    for (int c = 0; c < 16 && exp_q.size() != 0; c++) begin
      if (started) begin
        n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_gap: valid got %b want 1", inst_valid); end
      end
      if (inst_valid && inst_ready) begin
        started = 1;
        e = exp_q.pop_front();
        n_cmp++; if (inst_pc !== e[63:32]) begin n_fail++; $display("FAIL stream_pc: got %h want %h", inst_pc, e[63:32]); end
        n_cmp++; if (inst_data !== e[31:0]) begin n_fail++; $display("FAIL stream_data: got %h want %h", inst_data, e[31:0]); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_timeout: left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure;
    int pushes = 0;
    apply_reset(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (imem_req && imem_ack) pushes++;
      @(negedge clk);
    end
    n_cmp++; if (pushes != 2) begin n_fail++; $display("FAIL bp_pushes: got %0d want 2", pushes); end
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_full: got %b want 0", imem_req); end
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head: got %b@%h want 1@0", inst_valid, inst_pc); end
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'(i * 4)));
    inst_ready = 1'b1;
    #1;
    for (int c = 0; c < 16 && exp_q.size() != 0; c++) begin
      if (inst_valid && inst_ready) begin
        e = exp_q.pop_front();
        n_cmp++; if (inst_pc !== e[63:32]) begin n_fail++; $display("FAIL bp_pc: got %h want %h", inst_pc, e[63:32]); end
        n_cmp++; if (inst_data !== e[31:0]) begin n_fail++; $display("FAIL bp_data: got %h want %h", inst_data, e[31:0]); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_timeout: left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_discard;
    apply_reset(1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL dis_start: got %b@%h want 1@8", imem_req, imem_addr); end
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL dis_hold: got %b@%h want 1@8", imem_req, imem_addr); end
    n_cmp++; if (fetch_pc !== 32'h100) begin n_fail++; $display("FAIL dis_fetch_pc: got %h want 100", fetch_pc); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL dis_flush: got %b want 0", inst_valid); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL dis_hold3: got %h want 8", imem_addr); end
    imem_ack = 1'b1;
    exp_q.push_back(mk(32'h100));
    exp_q.push_back(mk(32'h104));
    @(negedge clk);
    n_cmp++; if (imem_addr !== 32'h100 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL dis_after_ack: got %h/%b want 100/0", imem_addr, inst_valid); end
    for (int c = 0; c < 12 && exp_q.size() != 0; c++) begin
      if (inst_valid && inst_ready) begin
        e = exp_q.pop_front();
        n_cmp++; if (inst_pc !== e[63:32]) begin n_fail++; $display("FAIL dis_pc: got %h want %h", inst_pc, e[63:32]); end
        n_cmp++; if (inst_data !== e[31:0]) begin n_fail++; $display("FAIL dis_data: got %h want %h", inst_data, e[31:0]); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL dis_timeout: left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_ack;
    apply_reset(1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL ra_pre: got %b/%h want 1/4", inst_valid, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL ra_flush: got %b want 0", inst_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL ra_addr: got %b@%h want 1@200", imem_req, imem_addr); end
    exp_q.push_back(mk(32'h200));
    exp_q.push_back(mk(32'h204));
    inst_ready = 1'b1;
    #1;
    for (int c = 0; c < 12 && exp_q.size() != 0; c++) begin
      if (inst_valid && inst_ready) begin
        e = exp_q.pop_front();
        n_cmp++; if (inst_pc !== e[63:32]) begin n_fail++; $display("FAIL ra_pc: got %h want %h", inst_pc, e[63:32]); end
        n_cmp++; if (inst_data !== e[31:0]) begin n_fail++; $display("FAIL ra_data: got %h want %h", inst_data, e[31:0]); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ra_timeout: left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_double_redirect;
    apply_reset(1'b0, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    n_cmp++; if (fetch_pc !== 32'h40 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL dr_first: got %h/%h want 40/0", fetch_pc, imem_addr); end
    redirect_pc = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (fetch_pc !== 32'h80 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL dr_second: got %h/%h want 80/0", fetch_pc, imem_addr); end
    imem_ack = 1'b1;
    exp_q.push_back(mk(32'h80));
    exp_q.push_back(mk(32'h84));
    @(negedge clk);
    n_cmp++; if (imem_addr !== 32'h80 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL dr_after_ack: got %h/%b want 80/0", imem_addr, inst_valid); end
    for (int c = 0; c < 12 && exp_q.size() != 0; c++) begin
      if (inst_valid && inst_ready) begin
        e = exp_q.pop_front();
        n_cmp++; if (inst_pc !== e[63:32]) begin n_fail++; $display("FAIL dr_pc: got %h want %h", inst_pc, e[63:32]); end
        n_cmp++; if (inst_data !== e[31:0]) begin n_fail++; $display("FAIL dr_data: got %h want %h", inst_data, e[31:0]); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL dr_timeout: left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_wrap;
    apply_reset(1'b1, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC || inst_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_addr: got %h/%b want fffffffc/0", imem_addr, inst_valid); end
    exp_q.push_back(mk(32'hFFFF_FFFC));
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    @(negedge clk);
    n_cmp++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_fetch_pc: got %h want 0", fetch_pc); end
    for (int c = 0; c < 12 && exp_q.size() != 0; c++) begin
      if (inst_valid && inst_ready) begin
        e = exp_q.pop_front();
        n_cmp++; if (inst_pc !== e[63:32]) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", inst_pc, e[63:32]); end
        n_cmp++; if (inst_data !== e[31:0]) begin n_fail++; $display("FAIL wrap_data: got %h want %h", inst_data, e[31:0]); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_timeout: left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_clr_mid_request;
    apply_reset(1'b0, 1'b1);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    clr_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || fetch_pc !== 32'h0) begin n_fail++; $display("FAIL clr_mid: got %b/%h want 0/0", imem_req, fetch_pc); end
    @(negedge clk);
    clr_n = 1'b1; imem_ack = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL clr_restart: got %b@%h want 1@0", imem_req, imem_addr); end
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    for (int c = 0; c < 12 && exp_q.size() != 0; c++) begin
      if (inst_valid && inst_ready) begin
        e = exp_q.pop_front();
        n_cmp++; if (inst_pc !== e[63:32]) begin n_fail++; $display("FAIL clr_pc: got %h want %h", inst_pc, e[63:32]); end
        n_cmp++; if (inst_data !== e[31:0]) begin n_fail++; $display("FAIL clr_data: got %h want %h", inst_data, e[31:0]); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clr_timeout: left %0d want 0", exp_q.size()); end
  endtask

  initial begin
    clr_n = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; inst_ready = 1'b0;
    #2;
    test_reset();
    test_stream();
    test_backpressure();
    test_discard();
    test_redirect_ack();
    test_double_redirect();
    test_wrap();
    test_clr_mid_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
